// File: rtl/bell_pkg.sv
`timescale 1ns/1ps
// Types and helpers shared by the bell button front end and the bell player.
package bell_pkg;

  localparam int N_BTN = 4;

  typedef logic [1:0] btn_id_t;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } fe_state_t;

  // Lowest set index wins, so btn1 (id 0) has the highest priority.
  function automatic btn_id_t lowest_set(input logic [N_BTN-1:0] mask);
    btn_id_t id;
    id = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (mask[k]) begin
        id = btn_id_t'(k);
      end
    end
    return id;
  endfunction

  function automatic logic [N_BTN-1:0] id_onehot(input btn_id_t id);
    logic [N_BTN-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// One button: metastability synchroniser followed by a consecutive-cycle debounce
// counter that only accepts a new level after DEB_CYCLES steady disagreeing samples.
module btn_debounce
  import bell_pkg::*;
#(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic _rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   level_reg;
  logic                   level_next;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // Any agreeing sample restarts the count; acceptance also restarts it.
  always_comb begin
    cnt_next   = '0;
    level_next = level_reg;
    if (s != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = s;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/bell_btn_frontend.sv
`timescale 1ns/1ps
// Door-bell button front end: debounces four buttons, latches presses into a
// pending mask and offers them one at a time, by priority, to the bell player.
module bell_btn_frontend
  import bell_pkg::*;
#(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             btn1,
  input  logic             btn2,
  input  logic             btn3,
  input  logic             btn4,
  output logic             req_valid,
  output logic [1:0]       req_id,
  input  logic             req_ready,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] pending
);

  logic [N_BTN-1:0] raw_vec;
  logic [N_BTN-1:0] lvl_d_reg;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] pending_reg;
  logic [N_BTN-1:0] pending_next;
  fe_state_t        state_reg;
  fe_state_t        state_next;
  btn_id_t          req_id_reg;
  btn_id_t          req_id_next;
  logic             req_valid_c;

  assign raw_vec = {btn4, btn3, btn2, btn1};

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES  (DEB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
      .clk   (clk),
      ._rst  (_rst),
      .raw   (raw_vec[gi]),
      .level (btn_level[gi])
    );
  end

  // Rising edge of the debounced level only; a held button yields one press.
  assign press = btn_level & ~lvl_d_reg;

  always_comb begin
    state_next  = state_reg;
    req_id_next = req_id_reg;
    clr         = '0;
    req_valid_c = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|pending_reg) begin
          req_id_next = lowest_set(pending_reg);
          state_next  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        req_valid_c = 1'b1;
        if (req_ready) begin
          clr        = id_onehot(req_id_reg);
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // A press landing on the accept cycle re-arms the same button.
    pending_next = (pending_reg & ~clr) | press;
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_reg   <= ST_IDLE;
      req_id_reg  <= '0;
      pending_reg <= '0;
      lvl_d_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      req_id_reg  <= req_id_next;
      pending_reg <= pending_next;
      lvl_d_reg   <= btn_level;
    end
  end

  assign req_valid = req_valid_c;
  assign req_id    = req_id_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_bell_btn_frontend.sv
`timescale 1ns/1ps
// Bench for bell_btn_frontend: behavioural reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button/ready traffic.
module tb_bell_btn_frontend;

  localparam int DEB  = 8;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn1, btn2, btn3, btn4;
  logic       req_ready;
  logic       req_valid;
  logic [1:0] req_id;
  logic [3:0] btn_level;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;
  int dut_acc[$];

  bell_btn_frontend #(
    .DEB_CYCLES  (DEB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    ._rst      (rst_n),
    .btn1      (btn1),
    .btn2      (btn2),
    .btn3      (btn3),
    .btn4      (btn4),
    .req_valid (req_valid),
    .req_id    (req_id),
    .req_ready (req_ready),
    .btn_level (btn_level),
    .pending   (pending)
  );

  always #1 clk = ~clk;

  // Reference model: raw samples delayed SYNC edges, a window of the last DEB
  // synced samples, and a pending set served lowest-id-first.
  logic [3:0] m_sync [SYNC];
  logic [3:0] m_win  [DEB];
  logic [3:0] m_level, m_rise, m_pend, m_s, m_all_diff, m_new_level, m_pend_next;
  logic       m_offer;
  logic [1:0] m_id;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_sync[k] = 4'h0;
      for (int k = 0; k < DEB; k++) m_win[k] = 4'h0;
      m_level = 4'h0;
      m_rise  = 4'h0;
      m_pend  = 4'h0;
      m_offer = 1'b0;
      m_id    = 2'd0;
    end else begin
      m_s = m_sync[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = {btn4, btn3, btn2, btn1};
      for (int k = DEB - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_s;
      m_all_diff = 4'hF;
      for (int k = 0; k < DEB; k++) m_all_diff = m_all_diff & (m_win[k] ^ m_level);
      m_new_level = m_level ^ m_all_diff;

      m_pend_next = m_pend;
      if (m_offer) begin
        if (req_ready) begin
          m_pend_next[m_id] = 1'b0;
          m_offer = 1'b0;
        end
      end else if (m_pend != 4'h0) begin
        for (int k = 3; k >= 0; k--) if (m_pend[k]) m_id = 2'(k);
        m_offer = 1'b1;
      end
      m_pend_next = m_pend_next | m_rise;
      m_rise  = m_new_level & ~m_level;
      m_level = m_new_level;
      m_pend  = m_pend_next;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_cmp();
    chk("model_cmp", 32'({btn_level, pending, req_valid, req_id}),
        32'({m_level, m_pend, m_offer, m_id}));
    if (req_valid && req_ready) dut_acc.push_back(int'(req_id));
  endtask

  // Return at the input-drive point, half a phase after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #0.5;
  endtask

  // Leaves the bench just after the edge where req_valid was first seen high.
  task automatic wait_valid(input string name, input int limit);
    int k;
    k = 0;
    while (k < limit) begin
      @(posedge clk);
      #1;
      if (req_valid) break;
      k++;
    end
    chk(name, 32'(req_valid), 32'd1);
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn4, btn3, btn2, btn1} = v;
  endtask

  int base;
  int nz;

  initial begin
    rst_n = 1'b1;
    req_ready = 1'b1;
    set_btns(4'hF);
    #0.2 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        model_cmp();
      end
    join_none

    // 1: buttons held through reset -> one press each, served 0..3.
    #0.3;
    chk("t1_rst_outputs", 32'({req_valid, req_id, btn_level, pending}), 32'd0);
    step(3);
    rst_n = 1'b1;
    base = dut_acc.size();
    step(30);
    set_btns(4'h0);
    chk("t1_acc_count", 32'(dut_acc.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < dut_acc.size()) chk("t1_acc_order", 32'(dut_acc[base+k]), 32'(k));
    end
    step(20);

    // 2: short glitch never registers.
    base = dut_acc.size();
    nz = 0;
    btn1 = 1'b1;
    step(3);
    btn1 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if ({btn_level, pending, req_valid} != 9'd0) nz++;
    end
    chk("t2_glitch_cycles", 32'(nz), 32'd0);
    chk("t2_acc_count", 32'(dut_acc.size() - base), 32'd0);
    step(1);

    // 3: latency from raw rise to req_valid, single request for a long hold.
    base = dut_acc.size();
    btn3 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t3_valid_e%0d", k), 32'(req_valid), 32'(k == 12));
      if (k == 12) chk("t3_id", 32'(req_id), 32'd2);
    end
    step(16);
    btn3 = 1'b0;
    step(20);
    chk("t3_pending", 32'(pending), 32'd0);
    chk("t3_acc_count", 32'(dut_acc.size() - base), 32'd1);

    // 4: simultaneous presses, stalled player, priority and idle gap.
    base = dut_acc.size();
    req_ready = 1'b0;
    set_btns(4'b1010);
    wait_valid("t4_wait", 30);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("t4_hold", 32'({req_valid, req_id}), 32'({1'b1, 2'd1}));
    end
    step(1);
    req_ready = 1'b1;
    @(negedge clk);
    chk("t4_pre_accept", 32'({req_valid, req_id}), 32'({1'b1, 2'd1}));
    @(negedge clk);
    chk("t4_gap", 32'(req_valid), 32'd0);
    @(negedge clk);
    chk("t4_second", 32'({req_valid, req_id}), 32'({1'b1, 2'd3}));
    step(2);
    set_btns(4'h0);
    step(20);
    chk("t4_acc_count", 32'(dut_acc.size() - base), 32'd2);

    // 5: repeated presses of a pending button merge.
    base = dut_acc.size();
    req_ready = 1'b0;
    btn1 = 1'b1; step(12);
    btn1 = 1'b0; step(12);
    btn1 = 1'b1; step(12);
    btn1 = 1'b0; step(20);
    chk("t5_pending", 32'(pending), 32'h1);
    req_ready = 1'b1;
    step(20);
    chk("t5_acc_count", 32'(dut_acc.size() - base), 32'd1);
    if (dut_acc.size() > base) chk("t5_acc_id", 32'(dut_acc[base]), 32'd0);

    // 6: asynchronous reset in the middle of an offer.
    req_ready = 1'b0;
    btn1 = 1'b1;
    wait_valid("t6_wait", 30);
    step(1);
    rst_n = 1'b0;
    btn1 = 1'b0;
    #0.1;
    chk("t6_async_drop", 32'({req_valid, pending, btn_level}), 32'd0);
    step(2);
    rst_n = 1'b1;
    req_ready = 1'b1;
    base = dut_acc.size();
    step(40);
    chk("t6_no_request", 32'(dut_acc.size() - base), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 11) == 0) begin
          case (b)
            0: btn1 = ~btn1;
            1: btn2 = ~btn2;
            2: btn3 = ~btn3;
            default: btn4 = ~btn4;
          endcase
        end
      end
      req_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    set_btns(4'h0);
    req_ready = 1'b1;
    step(40);
    chk("rand_drained", 32'({pending, req_valid}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
